// File: rtl/rv_defs_pkg.sv
// rtl/rv_defs_pkg.sv - shared RV definitions for the PC register, fetch and decode
// Purpose: machine width, canonical NOP encoding and the fetch buffer entry.
// Ports: none (package).
package rv_defs;

  localparam int XLEN = 32;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic            misalign;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - small synchronous FIFO of fetched instruction entries
// Purpose: buffers ROM responses between fetch and decode.
// Ports:
//   clk, rst      clock, synchronous active-low reset
//   push_i        write push_data_i at the tail
//   push_data_i   entry to write
//   pop_i         drop the head entry (caller guarantees non-empty)
//   flush_i       empty the FIFO; wins over push and pop
//   count_o       number of valid entries
//   head_o        oldest entry
module fetch_fifo
  import rv_defs::*;
#(
  parameter int DEPTH = 2,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  fetch_entry_t push_data_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output logic [AW:0]  count_o,
  output fetch_entry_t head_o
);

  fetch_entry_t        mem_q [DEPTH];
  logic [AW-1:0]       wr_ptr_q;
  logic [AW-1:0]       rd_ptr_q;
  logic [AW:0]         count_q;

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // Pointers are exactly log2(DEPTH) bits, so they wrap on their own.
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - instruction fetch stage between the PC register and decode
// Purpose: issues word reads to a 1-cycle synchronous ROM, buffers responses and
//          hands them to decode; holds the PC when out of buffer credit and
//          discards stale fetches on a redirect.
// Ports:
//   clk, rst         clock, synchronous active-low reset
//   pc_i             current PC
//   jump_en_i        redirect strobe (PC register loads the target this cycle)
//   pc_hold_o        PC must not advance
//   rom_req_o        ROM read enable
//   rom_addr_o       word-aligned ROM address
//   rom_rdata_i      ROM data, one cycle after rom_req_o
//   inst_valid_o     instruction available to decode
//   inst_o           instruction word (NOP when empty)
//   inst_addr_o      PC of inst_o (0 when empty)
//   inst_misalign_o  fetch PC was not word aligned
//   id_ready_i       decode accepts the instruction
module if_fetch
  import rv_defs::*;
#(
  parameter int XLEN  = rv_defs::XLEN,
  parameter int DEPTH = 2,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_i,
  input  logic            jump_en_i,
  output logic            pc_hold_o,
  output logic            rom_req_o,
  output logic [XLEN-1:0] rom_addr_o,
  input  logic [XLEN-1:0] rom_rdata_i,
  output logic            inst_valid_o,
  output logic [XLEN-1:0] inst_o,
  output logic [XLEN-1:0] inst_addr_o,
  output logic            inst_misalign_o,
  input  logic            id_ready_i
);

  localparam logic [AW+1:0] DEPTH_C = (AW+2)'(DEPTH);

  logic            pending_q, pending_d;
  logic [XLEN-1:0] pend_addr_q, pend_addr_d;
  logic            pend_mis_q, pend_mis_d;

  logic [AW:0]     count;
  logic [AW+1:0]   credit;
  logic            issue;
  logic            push;
  logic            pop;
  fetch_entry_t    push_entry;
  fetch_entry_t    head;

  // An in-flight read already owns a buffer slot, so credit counts it too.
  // Only registered state feeds this; id_ready_i and jump_en_i stay off the path.
  assign credit    = {1'b0, count} + {{(AW+1){1'b0}}, pending_q};
  assign pc_hold_o = rst && (credit >= DEPTH_C);

  assign issue      = rst && !pc_hold_o && !jump_en_i;
  assign rom_req_o  = issue;
  assign rom_addr_o = {pc_i[XLEN-1:2], 2'b00};

  always_comb begin
    pending_d   = issue;
    pend_addr_d = pend_addr_q;
    pend_mis_d  = pend_mis_q;
    if (issue) begin
      pend_addr_d = pc_i;
      pend_mis_d  = |pc_i[1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pending_q   <= 1'b0;
      pend_addr_q <= '0;
      pend_mis_q  <= 1'b0;
    end else begin
      pending_q   <= pending_d;
      pend_addr_q <= pend_addr_d;
      pend_mis_q  <= pend_mis_d;
    end
  end

  // A response landing in the redirect cycle belongs to the old path.
  assign push       = pending_q && !jump_en_i;
  assign pop        = inst_valid_o && id_ready_i;
  assign push_entry = '{addr: pend_addr_q, misalign: pend_mis_q, inst: rom_rdata_i};

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .flush_i     (jump_en_i),
    .count_o     (count),
    .head_o      (head)
  );

  assign inst_valid_o    = rst && (count != '0);
  assign inst_o          = inst_valid_o ? head.inst     : INST_NOP;
  assign inst_addr_o     = inst_valid_o ? head.addr     : '0;
  assign inst_misalign_o = inst_valid_o ? head.misalign : 1'b0;

endmodule

// File: tb/tb_if_fetch.sv
// tb/tb_if_fetch.sv - self-checking bench for if_fetch
module tb_if_fetch;

  localparam int DEPTH = 2;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_i;
  logic        jump_en_i;
  logic        pc_hold_o;
  logic        rom_req_o;
  logic [31:0] rom_addr_o;
  logic [31:0] rom_rdata_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        inst_misalign_o;
  logic        id_ready_i;

  if_fetch #(.XLEN(32), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .pc_i            (pc_i),
    .jump_en_i       (jump_en_i),
    .pc_hold_o       (pc_hold_o),
    .rom_req_o       (rom_req_o),
    .rom_addr_o      (rom_addr_o),
    .rom_rdata_i     (rom_rdata_i),
    .inst_valid_o    (inst_valid_o),
    .inst_o          (inst_o),
    .inst_addr_o     (inst_addr_o),
    .inst_misalign_o (inst_misalign_o),
    .id_ready_i      (id_ready_i)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return (a >> 2) + 32'd100;
  endfunction

  // ROM with one cycle read latency; junk when not read so stale data shows up.
  always @(posedge clk) begin
    if (rom_req_o) rom_rdata_i <= rom_word(rom_addr_o);
    else           rom_rdata_i <= $urandom;
  end

  typedef struct {
    logic [31:0] addr;
    logic        mis;
    logic [31:0] inst;
  } ent_t;

  // Reference: a queue of buffered fetches plus at most one read in flight.
  ent_t        mq[$];
  bit          m_pend;
  logic [31:0] m_pend_addr;
  logic [31:0] pc;

  int n_checks = 0;
  int n_fail   = 0;

  bit          e_hold, e_req, e_valid;
  logic [31:0] e_inst, e_addr;
  logic        e_mis;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit r, input bit j, input bit rdy);
    rst        = r;
    jump_en_i  = j;
    id_ready_i = rdy;
    pc_i       = pc;
    #1;
    e_hold  = r && ((mq.size() + int'(m_pend)) >= DEPTH);
    e_req   = r && !e_hold && !j;
    e_valid = r && (mq.size() > 0);
    e_inst  = e_valid ? mq[0].inst : NOP;
    e_addr  = e_valid ? mq[0].addr : 32'd0;
    e_mis   = e_valid ? mq[0].mis  : 1'b0;
  endtask

  task automatic check_model();
    chk("model_hold",  {31'd0, pc_hold_o},    {31'd0, e_hold});
    chk("model_req",   {31'd0, rom_req_o},    {31'd0, e_req});
    if (e_req) chk("model_rom_addr", rom_addr_o, {pc_i[31:2], 2'b00});
    chk("model_valid", {31'd0, inst_valid_o}, {31'd0, e_valid});
    chk("model_inst",  inst_o,                e_inst);
    chk("model_addr",  inst_addr_o,           e_addr);
    chk("model_mis",   {31'd0, inst_misalign_o}, {31'd0, e_mis});
  endtask

  task automatic advance(input logic [31:0] tgt);
    if (!rst) begin
      mq.delete();
      m_pend = 0;
      pc     = 32'd0;
    end else if (jump_en_i) begin
      mq.delete();
      m_pend = 0;
      pc     = tgt;
    end else begin
      if (e_valid && id_ready_i) void'(mq.pop_front());
      if (m_pend) mq.push_back('{m_pend_addr, |m_pend_addr[1:0], rom_word(m_pend_addr)});
      m_pend      = e_req;
      m_pend_addr = pc;
      if (e_req) pc = pc + 32'd4;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic step(input bit r, input bit j, input logic [31:0] tgt, input bit rdy);
    drive(r, j, rdy);
    check_model();
    advance(tgt);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 32'd0, 1'b1);
    step(1'b0, 1'b0, 32'd0, 1'b1);
  endtask

  // Reach the credit-full state of one buffered entry plus one read in flight.
  task automatic reach_full_pending(input string name);
    int n = 0;
    while (!(mq.size() == 1 && m_pend) && n < 20) begin
      step(1'b1, 1'b0, 32'd0, 1'b1);
      n++;
    end
    chk({name, "_reach_timeout"}, {31'd0, (mq.size() == 1 && m_pend)}, 32'd1);
  endtask

  typedef struct {
    bit          r, j, rdy;
    bit          e_valid;
    logic [31:0] e_addr, e_inst;
    bit          e_hold, e_req;
  } vec_t;

  vec_t vecs[8];

  initial begin
    rst = 1'b0; jump_en_i = 1'b0; id_ready_i = 1'b0; pc = 32'd0; pc_i = 32'd0;
    m_pend = 0; m_pend_addr = 32'd0;
    e_hold = 0; e_req = 0; e_valid = 0; e_inst = NOP; e_addr = 0; e_mis = 0;
    @(negedge clk);

    // Reset then streaming fetch from PC 0; credit rule shapes the cadence.
    vecs[0] = '{0, 0, 1, 0, 32'd0, NOP,       0, 0};
    vecs[1] = '{0, 0, 1, 0, 32'd0, NOP,       0, 0};
    vecs[2] = '{1, 0, 1, 0, 32'd0, NOP,       0, 1};
    vecs[3] = '{1, 0, 1, 0, 32'd0, NOP,       0, 1};
    vecs[4] = '{1, 0, 1, 1, 32'd0, 32'd100,   1, 0};
    vecs[5] = '{1, 0, 1, 1, 32'd4, 32'd101,   0, 1};
    vecs[6] = '{1, 0, 1, 0, 32'd0, NOP,       0, 1};
    vecs[7] = '{1, 0, 1, 1, 32'd8, 32'd102,   1, 0};
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].r, vecs[i].j, vecs[i].rdy);
      chk($sformatf("vec%0d_valid", i), {31'd0, inst_valid_o}, {31'd0, vecs[i].e_valid});
      chk($sformatf("vec%0d_addr",  i), inst_addr_o, vecs[i].e_addr);
      chk($sformatf("vec%0d_inst",  i), inst_o,      vecs[i].e_inst);
      chk($sformatf("vec%0d_hold",  i), {31'd0, pc_hold_o}, {31'd0, vecs[i].e_hold});
      chk($sformatf("vec%0d_req",   i), {31'd0, rom_req_o}, {31'd0, vecs[i].e_req});
      check_model();
      advance(32'd0);
    end

    // Decode stalls for 5 cycles: buffer fills, PC held, no requests.
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'd0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    chk("stall_hold", {31'd0, pc_hold_o}, 32'd1);
    chk("stall_req",  {31'd0, rom_req_o}, 32'd0);
    check_model();
    advance(32'd0);
    drive(1'b1, 1'b0, 1'b1);
    chk("drain_first", inst_addr_o, 32'd0);
    check_model();
    advance(32'd0);
    drive(1'b1, 1'b0, 1'b1);
    chk("drain_second", inst_addr_o, 32'd4);
    check_model();
    advance(32'd0);

    // Redirect when the PC reaches 12.
    begin
      int n = 0;
      while (pc != 32'd12 && n < 20) begin step(1'b1, 1'b0, 32'd0, 1'b1); n++; end
      chk("jump_reach_pc12", pc, 32'd12);
    end
    drive(1'b1, 1'b1, 1'b1);
    chk("jump_no_req", {31'd0, rom_req_o}, 32'd0);
    check_model();
    advance(32'd64);
    drive(1'b1, 1'b0, 1'b1);
    chk("jump_empty_next", {31'd0, inst_valid_o}, 32'd0);
    chk("jump_target_req", rom_addr_o, 32'd64);
    check_model();
    advance(32'd0);
    step(1'b1, 1'b0, 32'd0, 1'b1);
    drive(1'b1, 1'b0, 1'b1);
    chk("jump_target_addr", inst_addr_o, 32'd64);
    chk("jump_target_inst", inst_o, rom_word(32'd64));
    check_model();
    advance(32'd0);

    // Redirect with a push and a pop in the same cycle at full credit.
    reach_full_pending("flush");
    step(1'b1, 1'b1, 32'd128, 1'b1);
    drive(1'b1, 1'b0, 1'b1);
    chk("flush_empty", {31'd0, inst_valid_o}, 32'd0);
    check_model();
    advance(32'd0);
    step(1'b1, 1'b0, 32'd0, 1'b1);
    drive(1'b1, 1'b0, 1'b1);
    chk("flush_next_addr", inst_addr_o, 32'd128);
    check_model();
    advance(32'd0);

    // Misaligned PC.
    do_reset();
    pc = 32'd6;
    drive(1'b1, 1'b0, 1'b1);
    chk("mis_rom_addr", rom_addr_o, 32'd4);
    check_model();
    advance(32'd0);
    step(1'b1, 1'b0, 32'd0, 1'b1);
    drive(1'b1, 1'b0, 1'b1);
    chk("mis_flag", {31'd0, inst_misalign_o}, 32'd1);
    chk("mis_addr", inst_addr_o, 32'd6);
    chk("mis_inst", inst_o, 32'd101);
    check_model();
    advance(32'd0);

    // Reset with one entry buffered and one read in flight.
    reach_full_pending("rstmid");
    drive(1'b0, 1'b0, 1'b1);
    chk("rstmid_valid", {31'd0, inst_valid_o}, 32'd0);
    chk("rstmid_hold",  {31'd0, pc_hold_o},    32'd0);
    chk("rstmid_inst",  inst_o,                NOP);
    check_model();
    advance(32'd0);
    step(1'b0, 1'b0, 32'd0, 1'b1);
    step(1'b1, 1'b0, 32'd0, 1'b1);
    step(1'b1, 1'b0, 32'd0, 1'b1);
    drive(1'b1, 1'b0, 1'b1);
    chk("rstmid_clean_addr", inst_addr_o, 32'd0);
    chk("rstmid_clean_inst", inst_o, 32'd100);
    check_model();
    advance(32'd0);

    // Random traffic against the reference.
    for (int i = 0; i < 600; i++) begin
      bit          r, j, rdy;
      logic [31:0] tgt;
      r   = ($urandom_range(0, 59) != 0);
      j   = ($urandom_range(0, 9) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      tgt = {$urandom_range(0, 255), 2'b00} | (($urandom_range(0, 7) == 0) ? 32'd2 : 32'd0);
      step(r, j, tgt, rdy);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
